// File: rtl/nn_ram_pkg.sv
// Shared types and default widths for the weight-RAM access path.
package nn_ram_pkg;

    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } arb_state_t;

    typedef enum logic {
        READER = 1'b0,
        WRITER = 1'b1
    } owner_t;

    // Counter width able to hold 0..max_beats inclusive.
    function automatic int unsigned beat_cnt_w(input int unsigned max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker; remembers who was granted last and favours the other on a tie.
module rr_arbiter2
    import nn_ram_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_rd,
    input  logic req_wr,
    output logic gnt_rd_c,
    output logic gnt_wr_c
);

    owner_t last_owner;

    always_comb begin
        gnt_rd_c = 1'b0;
        gnt_wr_c = 1'b0;
        if (en) begin
            if (req_rd && (!req_wr || last_owner == WRITER)) begin
                gnt_rd_c = 1'b1;
            end else if (req_wr) begin
                gnt_wr_c = 1'b1;
            end
        end
    end

    // Writer is the reset owner so the reader wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= WRITER;
        end else if (gnt_rd_c) begin
            last_owner <= READER;
        end else if (gnt_wr_c) begin
            last_owner <= WRITER;
        end
    end

endmodule

// File: rtl/weight_ram_arbiter.sv
// Burst-granular arbiter sharing the single-port weight RAM between the inference
// read path and the host weight-load write path, with a max-burst forced release.
module weight_ram_arbiter
    import nn_ram_pkg::*;
#(
    parameter int unsigned ADDR_W    = nn_ram_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W    = nn_ram_pkg::DEF_DATA_W,
    parameter int unsigned MAX_BURST = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_last,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_gnt,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              burst_overrun
);

    localparam int unsigned CNT_W = beat_cnt_w(MAX_BURST);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_cnt_d;
    logic             overrun_d;
    logic             arb_rd_c;
    logic             arb_wr_c;
    logic             rd_beat_c;
    logic             wr_beat_c;
    logic             beat_c;
    logic             last_c;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .reset    (reset),
        .en       (state_q == IDLE),
        .req_rd   (rd_req),
        .req_wr   (wr_req),
        .gnt_rd_c (arb_rd_c),
        .gnt_wr_c (arb_wr_c)
    );

    assign rd_beat_c = rd_gnt & rd_req;
    assign wr_beat_c = wr_gnt & wr_req;
    assign beat_c    = rd_beat_c | wr_beat_c;
    assign last_c    = rd_gnt ? rd_last : wr_last;

    // Next-state: arbitrate in IDLE, count beats in a burst, release on last or overrun.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt;
        overrun_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                if (arb_rd_c) begin
                    state_d = RD_BURST;
                end else if (arb_wr_c) begin
                    state_d = WR_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (beat_c) begin
                    if (last_c) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else if (beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        overrun_d  = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            beat_cnt      <= '0;
            rd_gnt        <= 1'b0;
            wr_gnt        <= 1'b0;
            busy          <= 1'b0;
            rd_valid      <= 1'b0;
            burst_overrun <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt      <= beat_cnt_d;
            rd_gnt        <= (state_d == RD_BURST);
            wr_gnt        <= (state_d == WR_BURST);
            busy          <= (state_d != IDLE);
            rd_valid      <= rd_beat_c;
            burst_overrun <= overrun_d;
        end
    end

    // RAM port follows the owner only; the waiting requester never reaches the macro.
    always_comb begin
        ram_en   = beat_c;
        ram_we   = wr_beat_c;
        ram_addr = '0;
        ram_din  = '0;
        if (rd_gnt) begin
            ram_addr = rd_addr;
        end else if (wr_gnt) begin
            ram_addr = wr_addr;
            ram_din  = wr_data;
        end
    end

    assign rd_data = ram_dout;

endmodule

// File: tb/tb_weight_ram_arbiter.sv
// Directed bench for weight_ram_arbiter with a behavioural 1-cycle-read RAM model.
module tb_weight_ram_arbiter;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              wr_gnt;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              busy;
    logic              burst_overrun;

    int checks = 0;
    int passes = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    weight_ram_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_last       (rd_last),
        .rd_gnt        (rd_gnt),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_last       (wr_last),
        .wr_gnt        (wr_gnt),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .ram_dout      (ram_dout),
        .busy          (busy),
        .burst_overrun (burst_overrun)
    );

    // RAM preloaded with mem[a] = a[7:0]; 1-cycle synchronous read.
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i);
        ram_dout = '0;
    end

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout      <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_req  = 1'b0;
        rd_addr = '0;
        rd_last = 1'b0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_last = 1'b0;
    endtask

    // Holds reset for two edges and releases it just after an edge.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #2;

        // Reset state
        reset = 1'b0;
        #2;
        chk("rst_rd_gnt", 32'(rd_gnt), 32'd0);
        chk("rst_wr_gnt", 32'(wr_gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_overrun", 32'(burst_overrun), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);

        // Test 1 / 6: 4-beat read burst, last coincides with beat MAX_BURST
        do_reset();
        rd_req = 1'b1; rd_addr = 10'd0;
        #1;
        chk("t1_first_seen_gnt", 32'(rd_gnt), 32'd0);
        chk("t1_first_seen_en", 32'(ram_en), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            rd_addr = 10'(i);
            rd_last = (i == 3);
            #1;
            chk("t1_rd_gnt", 32'(rd_gnt), 32'd1);
            chk("t1_busy", 32'(busy), 32'd1);
            chk("t1_ram_en", 32'(ram_en), 32'd1);
            chk("t1_ram_addr", 32'(ram_addr), 32'(i));
            if (i > 0) begin
                chk("t1_rd_valid", 32'(rd_valid), 32'd1);
                chk("t1_rd_data", 32'(rd_data), 32'(i - 1));
            end
        end
        cyc();
        rd_req = 1'b0; rd_last = 1'b0;
        #1;
        chk("t1_gnt_drop", 32'(rd_gnt), 32'd0);
        chk("t1_busy_drop", 32'(busy), 32'd0);
        chk("t1_last_valid", 32'(rd_valid), 32'd1);
        chk("t1_last_data", 32'(rd_data), 32'd3);
        chk("t6_no_overrun", 32'(burst_overrun), 32'd0);
        cyc();
        #1;
        chk("t1_valid_clear", 32'(rd_valid), 32'd0);

        // Test 2: simultaneous requests after reset, reader first then writer
        do_reset();
        rd_req = 1'b1; rd_addr = 10'd8;
        wr_req = 1'b1; wr_addr = 10'd16; wr_data = 8'hA5;
        cyc();
        #1;
        chk("t2_rd_first", 32'(rd_gnt), 32'd1);
        chk("t2_wr_wait", 32'(wr_gnt), 32'd0);
        chk("t2_rd_we", 32'(ram_we), 32'd0);
        chk("t2_rd_addr", 32'(ram_addr), 32'd8);
        chk("t2_rd_din", 32'(ram_din), 32'd0);
        cyc();
        rd_addr = 10'd9; rd_last = 1'b1;
        #1;
        chk("t2_rd_addr2", 32'(ram_addr), 32'd9);
        cyc();
        rd_req = 1'b0; rd_last = 1'b0;
        #1;
        chk("t2_idle_rd_gnt", 32'(rd_gnt), 32'd0);
        chk("t2_idle_wr_gnt", 32'(wr_gnt), 32'd0);
        chk("t2_idle_en", 32'(ram_en), 32'd0);
        chk("t2_rd_data", 32'(rd_data), 32'd9);
        cyc();
        #1;
        chk("t2_wr_gnt", 32'(wr_gnt), 32'd1);
        chk("t2_wr_we", 32'(ram_we), 32'd1);
        chk("t2_wr_din", 32'(ram_din), 32'hA5);
        chk("t2_wr_addr", 32'(ram_addr), 32'd16);
        cyc();
        wr_addr = 10'd17; wr_data = 8'h5A; wr_last = 1'b1;
        #1;
        chk("t2_wr_din2", 32'(ram_din), 32'h5A);
        cyc();
        wr_req = 1'b0; wr_last = 1'b0;
        #1;
        chk("t2_wr_drop", 32'(wr_gnt), 32'd0);
        chk("t2_we_drop", 32'(ram_we), 32'd0);

        // Test 3: write burst with a 3-cycle stall; stall must not count as beats
        do_reset();
        wr_req = 1'b1; wr_addr = 10'd32; wr_data = 8'h11;
        cyc();
        #1;
        chk("t3_beat1_en", 32'(ram_en), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            wr_req = 1'b0;
            #1;
            chk("t3_stall_gnt", 32'(wr_gnt), 32'd1);
            chk("t3_stall_en", 32'(ram_en), 32'd0);
            chk("t3_stall_we", 32'(ram_we), 32'd0);
        end
        for (int i = 1; i < 4; i++) begin
            cyc();
            wr_req = 1'b1; wr_addr = 10'(32 + i); wr_data = 8'(8'h11 * (i + 1));
            wr_last = (i == 3);
            #1;
            chk("t3_beat_gnt", 32'(wr_gnt), 32'd1);
            chk("t3_beat_din", 32'(ram_din), 32'(8'h11 * (i + 1)));
            chk("t3_beat_overrun", 32'(burst_overrun), 32'd0);
        end
        cyc();
        wr_req = 1'b0; wr_last = 1'b0;
        #1;
        chk("t3_release", 32'(wr_gnt), 32'd0);
        chk("t3_no_overrun", 32'(burst_overrun), 32'd0);

        // Test 4: 6-beat read without last -> forced release after 4, writer next
        do_reset();
        rd_req = 1'b1; rd_addr = 10'h40;
        for (int i = 0; i < 4; i++) begin
            cyc();
            rd_addr = 10'(10'h40 + i);
            if (i == 1) begin
                wr_req = 1'b1; wr_addr = 10'h80; wr_data = 8'h77;
            end
            #1;
            chk("t4_rd_gnt", 32'(rd_gnt), 32'd1);
            chk("t4_wr_blocked", 32'(wr_gnt), 32'd0);
            chk("t4_we", 32'(ram_we), 32'd0);
            chk("t4_addr", 32'(ram_addr), 32'(10'h40 + i));
            chk("t4_overrun_low", 32'(burst_overrun), 32'd0);
        end
        cyc();
        rd_addr = 10'h44;
        #1;
        chk("t4_forced_drop", 32'(rd_gnt), 32'd0);
        chk("t4_overrun", 32'(burst_overrun), 32'd1);
        chk("t4_idle_en", 32'(ram_en), 32'd0);
        chk("t4_last_data", 32'(rd_data), 32'h43);
        cyc();
        wr_last = 1'b1;
        #1;
        chk("t4_wr_next", 32'(wr_gnt), 32'd1);
        chk("t4_rd_not", 32'(rd_gnt), 32'd0);
        chk("t4_overrun_pulse", 32'(burst_overrun), 32'd0);
        chk("t4_wr_we", 32'(ram_we), 32'd1);
        chk("t4_wr_addr", 32'(ram_addr), 32'h80);
        cyc();
        idle_inputs();
        #1;
        chk("t4_wr_drop", 32'(wr_gnt), 32'd0);

        // Test 5: asynchronous reset during beat 2 of a read burst
        do_reset();
        rd_req = 1'b1; rd_addr = 10'h50;
        cyc();
        cyc();
        rd_addr = 10'h51;
        #1;
        chk("t5_pre_gnt", 32'(rd_gnt), 32'd1);
        chk("t5_pre_valid", 32'(rd_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_rst_gnt", 32'(rd_gnt), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_valid", 32'(rd_valid), 32'd0);
        chk("t5_rst_en", 32'(ram_en), 32'd0);
        idle_inputs();
        cyc();
        cyc();
        reset = 1'b1;
        rd_req = 1'b1; rd_addr = 10'h60;
        wr_req = 1'b1; wr_addr = 10'h70;
        cyc();
        rd_last = 1'b1;
        #1;
        chk("t5_rd_first", 32'(rd_gnt), 32'd1);
        chk("t5_wr_wait", 32'(wr_gnt), 32'd0);
        chk("t5_addr", 32'(ram_addr), 32'h60);
        cyc();
        idle_inputs();
        #1;
        chk("t5_done", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
